// File: rtl/axis2lbus.sv
// axis2lbus: 512-bit AXI4-Stream to 4-segment (4x128) LBUS transmit converter.
// Each accepted AXIS beat becomes one LBUS cycle (seg0 = tdata[511:384]).
// A small beat buffer absorbs the one-cycle tx_rdy sampling delay of the MAC.
// Optional build macro: AXIS2LBUS_TUSER_ERR_EN adds s_axis_tuser, which is
// reported as tx_lbus_segN_err on the eop segment of the packet.
module axis2lbus #(
  parameter int BUF_DEPTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [511:0]         s_axis_tdata,
  input  logic [63:0]          s_axis_tkeep,
  input  logic                 s_axis_tlast,
`ifdef AXIS2LBUS_TUSER_ERR_EN
  input  logic                 s_axis_tuser,
`endif
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [127:0]         tx_lbus_seg0_data,
  output logic                 tx_lbus_seg0_ena,
  output logic                 tx_lbus_seg0_sop,
  output logic                 tx_lbus_seg0_eop,
  output logic [3:0]           tx_lbus_seg0_mty,
  output logic                 tx_lbus_seg0_err,
  output logic [127:0]         tx_lbus_seg1_data,
  output logic                 tx_lbus_seg1_ena,
  output logic                 tx_lbus_seg1_sop,
  output logic                 tx_lbus_seg1_eop,
  output logic [3:0]           tx_lbus_seg1_mty,
  output logic                 tx_lbus_seg1_err,
  output logic [127:0]         tx_lbus_seg2_data,
  output logic                 tx_lbus_seg2_ena,
  output logic                 tx_lbus_seg2_sop,
  output logic                 tx_lbus_seg2_eop,
  output logic [3:0]           tx_lbus_seg2_mty,
  output logic                 tx_lbus_seg2_err,
  output logic [127:0]         tx_lbus_seg3_data,
  output logic                 tx_lbus_seg3_ena,
  output logic                 tx_lbus_seg3_sop,
  output logic                 tx_lbus_seg3_eop,
  output logic [3:0]           tx_lbus_seg3_mty,
  output logic                 tx_lbus_seg3_err,
  input  logic                 tx_rdy,
  input  logic                 tx_ovfout,
  input  logic                 tx_unfout,
  output logic [CNT_WIDTH-1:0] stat_unf_cnt,
  output logic [CNT_WIDTH-1:0] stat_drop_cnt,
  output logic                 stat_mac_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  // One buffered LBUS cycle; per-segment fields are indexed by segment number.
  typedef struct packed {
    logic [511:0] data;
    logic [3:0]   ena;
    logic [3:0]   sop;
    logic [3:0]   eop;
    logic [15:0]  mty;
`ifdef AXIS2LBUS_TUSER_ERR_EN
    logic         err;
`endif
  } entry_t;

  // Saturating increment for the status counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Map one AXIS beat onto the four LBUS segments. Empty-byte counts are only
  // kept on the eop segment; eop goes on the highest enabled segment.
  function automatic entry_t pack_beat(input logic [511:0] d,
                                       input logic [63:0]  k,
                                       input logic         last,
                                       input logic         first);
    entry_t      e;
    logic [15:0] sl;
    logic [3:0]  z;
    logic [15:0] zall;
    logic [1:0]  hi;
    e    = '0;
    zall = '0;
    hi   = '0;
    e.data = d;
    for (int i = 0; i < 4; i++) begin
      sl = k[63-16*i -: 16];
      e.ena[i] = |sl;
      z = '0;
      for (int j = 0; j < 16; j++) z = z + {3'b000, ~sl[j]};
      zall[4*i +: 4] = z;
      if (e.ena[i]) hi = 2'(i);
    end
    e.sop[0] = first;
    if (last && (|e.ena)) begin
      e.eop[hi]         = 1'b1;
      e.mty[4*hi +: 4]  = zall[4*hi +: 4];
    end
    return e;
  endfunction

  logic               run;
  logic               in_pkt;
  logic               pkt_open;
  logic               tx_rdy_q;
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [PTR_W:0]     count;
  logic               full;
  logic               empty;
  logic               acc;
  logic               bad;
  logic               vld_p0;
  logic               rd_en;
  entry_t             beat_p0;
  entry_t             head;
  entry_t             mem [BUF_DEPTH];
  entry_t             out_p1;
  logic               vld_p1;
  logic [3:0]         ena_o;
  logic [3:0]         sop_o;
  logic [3:0]         eop_o;
  logic [15:0]        mty_o;
  logic [3:0]         err_o;

  assign count         = wr_ptr - rd_ptr;
  assign full          = (count == (PTR_W+1)'(BUF_DEPTH));
  assign empty         = (wr_ptr == rd_ptr);
  assign s_axis_tready = run & ~full;
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign bad           = (s_axis_tkeep == 64'd0);
  assign vld_p0        = acc & ~bad;
  assign rd_en         = tx_rdy_q & ~empty;
  assign head          = mem[rd_ptr[PTR_W-1:0]];

  // Stage p0: pack the incoming beat into a buffer entry.
  always_comb begin
    beat_p0 = pack_beat(s_axis_tdata, s_axis_tkeep, s_axis_tlast, ~in_pkt);
`ifdef AXIS2LBUS_TUSER_ERR_EN
    beat_p0.err = s_axis_tuser & s_axis_tlast;
`endif
  end

  // Beat buffer storage; no reset needed since pointers qualify every read.
  always_ff @(posedge clk) begin
    if (vld_p0) mem[wr_ptr[PTR_W-1:0]] <= beat_p0;
  end

  // Input-side control: enable after reset, packet tracking, write pointer, drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      in_pkt        <= 1'b0;
      wr_ptr        <= '0;
      stat_drop_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (acc) in_pkt <= ~s_axis_tlast;
      if (vld_p0) wr_ptr <= wr_ptr + 1'b1;
      if (acc && bad) stat_drop_cnt <= sat_inc(stat_drop_cnt);
    end
  end

  // Output-side control: ready sampling, read pointer, open-packet and underflow tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_rdy_q     <= 1'b0;
      rd_ptr       <= '0;
      pkt_open     <= 1'b0;
      stat_unf_cnt <= '0;
      stat_mac_err <= 1'b0;
    end else begin
      tx_rdy_q <= tx_rdy;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (|head.eop)      pkt_open <= 1'b0;
        else if (|head.sop) pkt_open <= 1'b1;
      end
      if (tx_rdy_q && empty && pkt_open) stat_unf_cnt <= sat_inc(stat_unf_cnt);
      if (tx_ovfout || tx_unfout) stat_mac_err <= 1'b1;
    end
  end

  // Stage p1: LBUS output register; the entry holds when nothing is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) out_p1 <= head;
    end
  end

  assign ena_o = out_p1.ena & {4{vld_p1}};
  assign sop_o = out_p1.sop & {4{vld_p1}};
  assign eop_o = out_p1.eop & {4{vld_p1}};
  assign mty_o = out_p1.mty & {16{vld_p1}};
`ifdef AXIS2LBUS_TUSER_ERR_EN
  assign err_o = out_p1.eop & {4{vld_p1 & out_p1.err}};
`else
  assign err_o = 4'b0000;
`endif

  assign tx_lbus_seg0_data = out_p1.data[511:384];
  assign tx_lbus_seg1_data = out_p1.data[383:256];
  assign tx_lbus_seg2_data = out_p1.data[255:128];
  assign tx_lbus_seg3_data = out_p1.data[127:0];
  assign tx_lbus_seg0_ena  = ena_o[0];
  assign tx_lbus_seg1_ena  = ena_o[1];
  assign tx_lbus_seg2_ena  = ena_o[2];
  assign tx_lbus_seg3_ena  = ena_o[3];
  assign tx_lbus_seg0_sop  = sop_o[0];
  assign tx_lbus_seg1_sop  = sop_o[1];
  assign tx_lbus_seg2_sop  = sop_o[2];
  assign tx_lbus_seg3_sop  = sop_o[3];
  assign tx_lbus_seg0_eop  = eop_o[0];
  assign tx_lbus_seg1_eop  = eop_o[1];
  assign tx_lbus_seg2_eop  = eop_o[2];
  assign tx_lbus_seg3_eop  = eop_o[3];
  assign tx_lbus_seg0_mty  = mty_o[3:0];
  assign tx_lbus_seg1_mty  = mty_o[7:4];
  assign tx_lbus_seg2_mty  = mty_o[11:8];
  assign tx_lbus_seg3_mty  = mty_o[15:12];
  assign tx_lbus_seg0_err  = err_o[0];
  assign tx_lbus_seg1_err  = err_o[1];
  assign tx_lbus_seg2_err  = err_o[2];
  assign tx_lbus_seg3_err  = err_o[3];

endmodule

// File: tb/tb_axis2lbus.sv
// tb_axis2lbus: scoreboard bench for axis2lbus. Stimulus pushes the
// hand-derived LBUS cycle for each beat; a negedge monitor pops and compares.
module tb_axis2lbus;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
`ifdef AXIS2LBUS_TUSER_ERR_EN
  logic         s_axis_tuser;
`endif
  logic [127:0] d0, d1, d2, d3;
  logic         e0, e1, e2, e3, sp0, sp1, sp2, sp3, ep0, ep1, ep2, ep3;
  logic         r0, r1, r2, r3;
  logic [3:0]   m0, m1, m2, m3;
  logic         tx_rdy, tx_ovfout, tx_unfout;
  logic [15:0]  stat_unf_cnt, stat_drop_cnt;
  logic         stat_mac_err;

  always #5 clk = ~clk;

  axis2lbus #(.BUF_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
`ifdef AXIS2LBUS_TUSER_ERR_EN
    .s_axis_tuser(s_axis_tuser),
`endif
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .tx_lbus_seg0_data(d0), .tx_lbus_seg0_ena(e0), .tx_lbus_seg0_sop(sp0),
    .tx_lbus_seg0_eop(ep0), .tx_lbus_seg0_mty(m0), .tx_lbus_seg0_err(r0),
    .tx_lbus_seg1_data(d1), .tx_lbus_seg1_ena(e1), .tx_lbus_seg1_sop(sp1),
    .tx_lbus_seg1_eop(ep1), .tx_lbus_seg1_mty(m1), .tx_lbus_seg1_err(r1),
    .tx_lbus_seg2_data(d2), .tx_lbus_seg2_ena(e2), .tx_lbus_seg2_sop(sp2),
    .tx_lbus_seg2_eop(ep2), .tx_lbus_seg2_mty(m2), .tx_lbus_seg2_err(r2),
    .tx_lbus_seg3_data(d3), .tx_lbus_seg3_ena(e3), .tx_lbus_seg3_sop(sp3),
    .tx_lbus_seg3_eop(ep3), .tx_lbus_seg3_mty(m3), .tx_lbus_seg3_err(r3),
    .tx_rdy(tx_rdy), .tx_ovfout(tx_ovfout), .tx_unfout(tx_unfout),
    .stat_unf_cnt(stat_unf_cnt), .stat_drop_cnt(stat_drop_cnt),
    .stat_mac_err(stat_mac_err)
  );

  logic [511:0] got_data;
  logic [3:0]   got_ena, got_sop, got_eop, got_err;
  logic [15:0]  got_mty;
  assign got_data = {d0, d1, d2, d3};
  assign got_ena  = {e3, e2, e1, e0};
  assign got_sop  = {sp3, sp2, sp1, sp0};
  assign got_eop  = {ep3, ep2, ep1, ep0};
  assign got_err  = {r3, r2, r1, r0};
  assign got_mty  = {m3, m2, m1, m0};

  typedef struct {
    logic [511:0] data;
    logic [3:0]   ena;
    logic [3:0]   sop;
    logic [3:0]   eop;
    logic [15:0]  mty;
    logic [3:0]   err;
  } beat_t;

  beat_t sbq[$];
  int    tests = 0;
  int    fails = 0;
  int    out_beats = 0;
  bit    bp_done = 0;

  localparam logic [63:0] KFULL = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic beat_t mk(input logic [511:0] d, input logic [3:0] ena,
                               input logic [3:0] sop, input logic [3:0] eop,
                               input logic [15:0] mty, input logic [3:0] err);
    beat_t b;
    b.data = d; b.ena = ena; b.sop = sop; b.eop = eop; b.mty = mty; b.err = err;
    return b;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit ok;
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout tready stuck low");
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string name);
    int n = 0;
    while (out_beats < target && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (out_beats < target) begin
      tests++; fails++;
      $display("FAIL %s beats=%0d exp=%0d", name, out_beats, target);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    repeat (2) @(negedge clk);
    #1;
    chk(name, 64'(sbq.size()), 64'd0);
  endtask

  task automatic bp_sender();
    logic [511:0] d;
    for (int k = 1; k <= 8; k++) begin
      d = rnd512();
      sbq.push_back(mk(d, 4'hF, (k == 1) ? 4'h1 : 4'h0, (k == 8) ? 4'h8 : 4'h0, 16'h0, 4'h0));
      send_beat(d, KFULL, k == 8);
    end
    bp_done = 1;
  endtask

  // Monitor: every LBUS cycle with any segment enabled is one expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (got_ena != 4'h0) begin
        out_beats++;
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat ena=%h sop=%h eop=%h", got_ena, got_sop, got_eop);
        end else begin
          e = sbq.pop_front();
          if (got_data !== e.data || got_ena !== e.ena || got_sop !== e.sop ||
              got_eop !== e.eop || got_mty !== e.mty || got_err !== e.err) begin
            fails++;
            $display("FAIL lbus_beat got ena=%h sop=%h eop=%h mty=%h err=%h exp ena=%h sop=%h eop=%h mty=%h err=%h data_ok=%0d",
                     got_ena, got_sop, got_eop, got_mty, got_err,
                     e.ena, e.sop, e.eop, e.mty, e.err, got_data === e.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    int n0, n1, u0;
    rst_n = 1'b0; tx_rdy = 1'b1; tx_ovfout = 1'b0; tx_unfout = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
`ifdef AXIS2LBUS_TUSER_ERR_EN
    s_axis_tuser = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_ena", got_ena, 0);
    chk("rst_data", 64'(got_data != '0), 0);
    chk("rst_unf", stat_unf_cnt, 0);
    chk("rst_drop", stat_drop_cnt, 0);
    chk("rst_mac_err", stat_mac_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tready", s_axis_tready, 1);

    // 64-byte packet
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h8, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b1);
    @(negedge clk); #1; chk("p64_no_bypass", got_ena, 4'h0);
    @(negedge clk); #1; chk("p64_latency", got_ena, 4'hF);
    @(negedge clk); #1; chk("p64_idle_after", got_ena, 4'h0);
    drain("p64_drain");

    // 65-byte packet
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h0, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b0);
    d = rnd512();
    sbq.push_back(mk(d, 4'h1, 4'h0, 4'h1, 16'h000F, 4'h0));
    send_beat(d, 64'h8000_0000_0000_0000, 1'b1);
    drain("p65_drain");
    chk("p65_unf_zero", stat_unf_cnt, 0);

    // Back-pressure: drop tx_rdy right after the first beat shows up
    n0 = out_beats;
    bp_done = 0;
    fork
      bp_sender();
    join_none
    wait_beats(n0 + 1, "bp_first_beat");
    tx_rdy = 1'b0;
    n1 = out_beats;
    repeat (10) @(negedge clk);
    #1;
    chk("bp_max_one_after_drop", 64'((out_beats - n1) <= 1), 1);
    chk("bp_tready_low_full", s_axis_tready, 0);
    tx_rdy = 1'b1;
    begin
      int n = 0;
      while (!bp_done && n < 200) begin @(negedge clk); n++; end
    end
    chk("bp_sender_done", bp_done, 1);
    drain("bp_drain");
    chk("bp_beat_count", 64'(out_beats - n0), 8);

    // Underflow: 2-cycle tvalid gap after beat 1 of a 3-beat packet
    u0 = int'(stat_unf_cnt);
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h0, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h0, 4'h0, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b0);
    d = rnd512();
    sbq.push_back(mk(d, 4'h7, 4'h0, 4'h4, 16'h0800, 4'h0));
    send_beat(d, {16'hFFFF, 16'hFFFF, 16'hFF00, 16'h0000}, 1'b1);
    drain("unf_drain");
    chk("unf_count_2", 64'(int'(stat_unf_cnt) - u0), 2);

    // Malformed tlast beat mid-packet
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h0, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b0);
    send_beat(rnd512(), 64'h0, 1'b1);
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h8, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b1);
    drain("drop_drain");
    chk("drop_count_1", stat_drop_cnt, 1);

    // Sticky MAC error
    chk("mac_err_clear", stat_mac_err, 0);
    @(negedge clk); tx_unfout = 1'b1;
    @(negedge clk); tx_unfout = 1'b0;
    #1; chk("mac_err_set", stat_mac_err, 1);
    repeat (3) @(negedge clk);
    #1; chk("mac_err_sticky", stat_mac_err, 1);

    // Reset mid-packet
    n0 = out_beats;
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h0, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b0);
    wait_beats(n0 + 1, "mid_rst_beat");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ena", got_ena, 0);
    chk("mid_rst_sop", got_sop, 0);
    chk("mid_rst_data", 64'(got_data != '0), 0);
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_unf", stat_unf_cnt, 0);
    chk("mid_rst_drop", stat_drop_cnt, 0);
    chk("mid_rst_mac_err", stat_mac_err, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h8, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b1);
    drain("post_rst_drain");
    chk("post_rst_unf", stat_unf_cnt, 0);

`ifdef AXIS2LBUS_TUSER_ERR_EN
    s_axis_tuser = 1'b1;
    d = rnd512();
    sbq.push_back(mk(d, 4'hF, 4'h1, 4'h0, 16'h0, 4'h0));
    send_beat(d, KFULL, 1'b0);
    d = rnd512();
    sbq.push_back(mk(d, 4'h3, 4'h0, 4'h2, 16'h0, 4'h2));
    send_beat(d, {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}, 1'b1);
    s_axis_tuser = 1'b0;
    drain("tuser_drain");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis2lbus.md
Name: axis2lbus

Overview:
- TX-side counterpart of the LBUS receive converter: accepts 512-bit AXI4-Stream packets and drives the 4-segment (4x128-bit) LBUS transmit interface of the 100G MAC.
- Each AXIS beat maps to one LBUS cycle (seg0 = tdata[511:384]); sop/eop/mty are generated from packet state, tkeep and tlast.
- An internal buffer absorbs the MAC's tx_rdy back-pressure latency; underflow and overflow status is counted.

Parameters:
- BUF_DEPTH, 4, entries in the internal beat buffer (power of 2, >=4).
- CNT_WIDTH, 16, width of the status counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset (see interface rule below)
- s_axis_tdata  in  512  seg i occupies [511-128i : 384-128i]
- s_axis_tkeep  in  64  seg i occupies [63-16i : 48-16i]; contiguous, MSB-aligned per segment
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid&tready
- tx_lbus_seg{0..3}_data  out  128  segment data
- tx_lbus_seg{0..3}_ena  out  1  segment valid
- tx_lbus_seg{0..3}_sop  out  1  start of packet
- tx_lbus_seg{0..3}_eop  out  1  end of packet
- tx_lbus_seg{0..3}_mty  out  4  empty bytes in segment (eop only)
- tx_lbus_seg{0..3}_err  out  1  packet error (eop only)
- tx_rdy  in  1  MAC ready
- tx_ovfout  in  1  MAC overflow indication
- tx_unfout  in  1  MAC underflow indication
- stat_unf_cnt  out  CNT_WIDTH  mid-packet bubble cycles issued
- stat_drop_cnt  out  CNT_WIDTH  malformed beats dropped
- stat_mac_err  out  1  sticky: tx_ovfout or tx_unfout seen

Interface rule: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.

Behaviour:
- Reset (async, rst_n=0): all tx_lbus_* outputs 0, s_axis_tready 0, buffer empty, in_pkt=0, counters 0, stat_mac_err 0. Deassertion takes effect at the next clk edge.
- s_axis_tready = (buffer count < BUF_DEPTH) while out of reset.
- Input packing, on an accepted beat:
  - seg_ena[i] = |tkeep slice i.
  - mty[i] = number of zero bits in slice i.
  - sop is placed on seg0 when in_pkt=0.
  - eop is placed on the highest-index enabled segment when tlast=1; mty is forced 0 on non-eop segments.
- in_pkt: set on an accepted beat with tlast=0; cleared on an accepted beat with tlast=1.
- Malformed beat (tkeep==0): accepted, not written, stat_drop_cnt+1. If its tlast=1, in_pkt is cleared and no eop is emitted.
- Non-contiguous tkeep is undefined; nothing checks it.
- tx_rdy_q: tx_rdy registered once.
- Output register:
  - Loads the buffer head when tx_rdy_q=1 and the buffer is non-empty.
  - Otherwise all ena/sop/eop/err go to 0; data holds its last value.
  - Latency: beat accepted at edge N appears on LBUS after edge N+1 (minimum).
- Back-pressure: when tx_rdy drops at edge N, the last beat issued is the one loaded at edge N+1. The buffer keeps filling until full, then tready drops.
- Underflow count: stat_unf_cnt+1 on each edge where tx_rdy_q=1, the buffer is empty, and an LBUS packet is open. A packet is open when eop has not yet been emitted after an emitted sop. The counter saturates at all-ones.
- Simultaneous write and read on a full buffer: tready is already 0, so there is no write.
- Simultaneous write and read on an empty buffer: the write lands and is read at the next edge (no bypass).
- stat_drop_cnt saturates at all-ones.
- stat_mac_err is set by tx_ovfout|tx_unfout sampled high and is cleared only by reset.
- Pointer wrap: modulo BUF_DEPTH, with an extra bit to distinguish full from empty.

Optional Feature:
- AXIS2LBUS_TUSER_ERR_EN: adds port s_axis_tuser (in, 1): packet-bad flag, sampled on the tlast beat.
  - Defined: tx_lbus_segN_err = tuser on the eop segment, 0 elsewhere. The buffer entry gains one bit.
  - Undefined: no tuser port; all err outputs are tied 0.

Test Plan:
- 64-byte packet: one beat, tkeep=all-ones, tlast=1, tx_rdy=1 -> two edges later seg0 sop=1, seg3 eop=1 mty=0, all ena=1; next cycle all ena=0.
- 65-byte packet: beat 1 full; beat 2 tkeep=64'h8000_0000_0000_0000, tlast=1 -> second LBUS cycle: seg0 ena=1 eop=1 mty=15, seg1..3 ena=0, sop only in the first cycle.
- tx_rdy=0 for 10 cycles while 8 beats are offered -> at most 1 beat issued after the drop; tready low once 4 entries are buffered; no beat lost or duplicated after tx_rdy returns.
- 3-beat packet with an s_axis_tvalid gap of 2 cycles after beat 1 -> stat_unf_cnt=2.
- tkeep=0 beat with tlast=1 mid-packet -> stat_drop_cnt=1; next accepted beat carries sop.
- rst_n pulsed low mid-packet -> outputs 0 immediately; first post-reset beat carries sop; counters 0. With the macro defined, tuser=1 on the tlast beat -> err=1 on the eop segment only.
